// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read-side and stream handshake bundle for fifo_rd_stream
interface fifo_rd_stream_if #(
  parameter int DATASIZE = 4
);
  logic                fifo_empty;
  logic                fifo_rd_en;
  logic [DATASIZE-1:0] fifo_data;
  logic                m_valid;
  logic                m_ready;
  logic [DATASIZE-1:0] m_data;
  logic [1:0]          level;
  logic [15:0]         xfer_cnt;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, level, xfer_cnt
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, level, xfer_cnt
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream with 2-entry skid buffer
module fifo_rd_stream #(
  parameter int DATASIZE = 4
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  fifo_rd_stream_if.master  bus
);

  // State encodes the buffered entry count directly so level is the state value.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                pend;
  logic [DATASIZE-1:0] slot0;
  logic [DATASIZE-1:0] slot1;
  logic [DATASIZE-1:0] slot0_next;
  logic [DATASIZE-1:0] slot1_next;
  logic [15:0]         xfer_cnt_q;
  logic                pop;
  logic                push;
  logic                rd_en;
  logic [2:0]          occ;

  assign pop  = bus.m_valid & bus.m_ready;
  assign push = pend;

  // Occupancy after this edge, counting the read already in flight; never negative since pop needs count >= 1.
  assign occ   = {1'b0, state} + {2'b00, pend} - {2'b00, pop};
  assign rd_en = ~rd_rst & ~bus.fifo_empty & (occ < 3'd2);

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = TWO;
        else if (!push && pop) state_next = EMPTY;
      end
      TWO:   if (pop && !push) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    slot0_next = slot0;
    slot1_next = slot1;
    if (pop && state == TWO) slot0_next = slot1;
    // Arriving data lands in the head only when the head is free after this pop.
    if (push) begin
      if (state == EMPTY || (state == ONE && pop)) slot0_next = bus.fifo_data;
      else                                         slot1_next = bus.fifo_data;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= EMPTY;
      pend       <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      xfer_cnt_q <= 16'd0;
    end else begin
      state <= state_next;
      pend  <= rd_en;
      slot0 <= slot0_next;
      slot1 <= slot1_next;
      if (pop) xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (state != EMPTY);
  assign bus.m_data     = slot0;
  assign bus.level      = state;
  assign bus.xfer_cnt   = xfer_cnt_q;

endmodule
